// File: rtl/alu_pkg.sv
// Shared ALU definitions: default datapath width and the serial-unit FSM states.
package alu_pkg;

  localparam int ALU_SIZE = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    FINISH = 2'd2
  } neg_state_e;

endpackage

// File: rtl/serial_negate_neg_bit_cell.sv
// One bit of the serial negation: half-adder applied to the inverted operand bit.
module neg_bit_cell (
  input  logic d,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = ~d ^ cin;
  assign cout = ~d & cin;

endmodule

// File: rtl/serial_negate.sv
// Bit-serial two's-complement negation, LSB first, one bit per clock.
// Optional overflow flag is enabled by defining SERIAL_NEGATE_OVF_EN.
module serial_negate
  import alu_pkg::*;
#(
  parameter int size = ALU_SIZE
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic            START,
  input  logic [size-1:0] Q,
  output logic            BUSY,
  output logic            DONE,
  output logic [size-1:0] Q_NEG
`ifdef SERIAL_NEGATE_OVF_EN
  ,
  output logic            OVF
`endif
);

  localparam int CW = (size > 1) ? $clog2(size) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(size - 1);

  neg_state_e      state_q;
  logic [size-1:0] sr_q;
  logic [size-1:0] acc_q;
  logic [CW-1:0]   cnt_q;
  logic            carry_q;
  logic            busy_q;
  logic            done_q;
  logic [size-1:0] q_neg_q;
  logic            bit_d;
  logic            carry_d;
`ifdef SERIAL_NEGATE_OVF_EN
  logic            op_msb_q;
  logic            ovf_q;
`endif

  neg_bit_cell u_cell (
    .d    (sr_q[0]),
    .cin  (carry_q),
    .s    (bit_d),
    .cout (carry_d)
  );

  // Control FSM with the datapath and output registers; BUSY follows the next state.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= IDLE;
      sr_q     <= {size{1'b0}};
      acc_q    <= {size{1'b0}};
      cnt_q    <= {CW{1'b0}};
      carry_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      q_neg_q  <= {size{1'b0}};
`ifdef SERIAL_NEGATE_OVF_EN
      op_msb_q <= 1'b0;
      ovf_q    <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (START) begin
            sr_q     <= Q;
            carry_q  <= 1'b1;
            cnt_q    <= {CW{1'b0}};
            state_q  <= SHIFT;
            busy_q   <= 1'b1;
`ifdef SERIAL_NEGATE_OVF_EN
            op_msb_q <= Q[size-1];
`endif
          end else begin
            busy_q <= 1'b0;
          end
        end
        SHIFT: begin
          sr_q    <= sr_q >> 1;
          carry_q <= carry_d;
          acc_q   <= {bit_d, acc_q[size-1:1]};
          busy_q  <= 1'b1;
          // Counter stops at the last bit so it never wraps.
          if (cnt_q == CNT_LAST) begin
            state_q <= FINISH;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        FINISH: begin
          q_neg_q <= acc_q;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
`ifdef SERIAL_NEGATE_OVF_EN
          ovf_q   <= op_msb_q & acc_q[size-1];
`endif
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign BUSY  = busy_q;
  assign DONE  = done_q;
  assign Q_NEG = q_neg_q;
`ifdef SERIAL_NEGATE_OVF_EN
  assign OVF   = ovf_q;
`endif

endmodule

// File: tb/tb_serial_negate.sv
// Self-checking bench for serial_negate (8-bit): directed vector table,
// hand-written corner sequences and randomized operands against an arithmetic model.
module tb_serial_negate;

  localparam int W      = 8;
  localparam int PERIOD = 10;

  logic         CLK;
  logic         RST_N;
  logic         START;
  logic [W-1:0] Q;
  logic         BUSY;
  logic         DONE;
  logic [W-1:0] Q_NEG;
`ifdef SERIAL_NEGATE_OVF_EN
  logic         OVF;
`endif

  int  n_tests;
  int  n_fail;
  int  done_cnt;
  time last_done_t;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] neg;
    logic         ovf;
  } vec_t;

  vec_t vecs[6];

  serial_negate #(.size(W)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .START (START),
    .Q     (Q),
    .BUSY  (BUSY),
    .DONE  (DONE),
    .Q_NEG (Q_NEG)
`ifdef SERIAL_NEGATE_OVF_EN
    ,
    .OVF   (OVF)
`endif
  );

  initial CLK = 1'b0;
  always #(PERIOD / 2) CLK = ~CLK;

  always @(negedge CLK) begin
    if (DONE === 1'b1) done_cnt++;
  end

  task automatic chk(input string name, input longint act, input longint exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: negation modulo 2^W, overflow only for the most-negative value.
  function automatic logic [W-1:0] model_neg(input logic [W-1:0] q);
    int r;
    r = ((1 << W) - int'(q)) % (1 << W);
    return W'(r);
  endfunction

  function automatic logic model_ovf(input logic [W-1:0] q);
    return (int'(q) == (1 << (W - 1)));
  endfunction

  task automatic chk_ovf(input string name, input logic exp);
`ifdef SERIAL_NEGATE_OVF_EN
    chk(name, OVF, exp);
`else
    if (exp !== 1'b0 && exp !== 1'b1) chk(name, 0, 1);
`endif
  endtask

  // Called at a negedge; drives START for one cycle, optionally re-pulses
  // START (Q=0x33) at relative cycle inj_k, returns at the negedge showing DONE.
  task automatic do_op(input logic [W-1:0] q, input logic [W-1:0] exp_neg,
                       input logic exp_ovf, input int inj_k);
    int k;
    int busy_n;
    START = 1'b1;
    Q     = q;
    @(negedge CLK);
    START = 1'b0;
    Q     = W'($urandom);
    k = 0;
    busy_n = 0;
    while (DONE !== 1'b1 && k < 40) begin
      if (BUSY === 1'b1) busy_n++;
      if (k == inj_k) begin
        START = 1'b1;
        Q     = 8'h33;
      end else begin
        START = 1'b0;
      end
      @(negedge CLK);
      k++;
    end
    START = 1'b0;
    chk("latency", k, W + 1);
    chk("busy_cycles", busy_n, W + 1);
    chk("busy_low_at_done", BUSY, 0);
    chk("q_neg", Q_NEG, exp_neg);
    chk_ovf("ovf", exp_ovf);
    last_done_t = $time;
  endtask

  initial begin
    int  d0;
    time t1;
    logic [W-1:0] rq;

    n_tests  = 0;
    n_fail   = 0;
    done_cnt = 0;
    RST_N    = 1'b0;
    START    = 1'b0;
    Q        = 8'h00;

    vecs[0] = '{q: 8'h05, neg: 8'hFB, ovf: 1'b0};
    vecs[1] = '{q: 8'h00, neg: 8'h00, ovf: 1'b0};
    vecs[2] = '{q: 8'h80, neg: 8'h80, ovf: 1'b1};
    vecs[3] = '{q: 8'h7F, neg: 8'h81, ovf: 1'b0};
    vecs[4] = '{q: 8'h01, neg: 8'hFF, ovf: 1'b0};
    vecs[5] = '{q: 8'hFF, neg: 8'h01, ovf: 1'b0};

    repeat (3) @(negedge CLK);
    chk("rst_busy", BUSY, 0);
    chk("rst_done", DONE, 0);
    chk("rst_q_neg", Q_NEG, 0);
    chk_ovf("rst_ovf", 1'b0);
    RST_N = 1'b1;
    repeat (4) @(negedge CLK);
    chk("idle_busy", BUSY, 0);
    chk("idle_done", DONE, 0);
    chk("idle_q_neg", Q_NEG, 0);

    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      do_op(vecs[i].q, vecs[i].neg, vecs[i].ovf, -1);
      @(negedge CLK);
      chk("done_one_cycle", DONE, 0);
      chk("q_neg_holds", Q_NEG, vecs[i].neg);
    end

    // START re-pulsed mid-SHIFT must be ignored.
    @(negedge CLK);
    d0 = done_cnt;
    do_op(8'h05, 8'hFB, 1'b0, 3);
    repeat (12) @(negedge CLK);
    chk("single_done_pulse", done_cnt - d0, 1);
    chk("q_neg_after_ignored", Q_NEG, 8'hFB);

    // Reset in the middle of a conversion abandons it.
    @(negedge CLK);
    START = 1'b1;
    Q     = 8'h7F;
    @(negedge CLK);
    START = 1'b0;
    repeat (3) @(negedge CLK);
    chk("busy_before_reset", BUSY, 1);
    RST_N = 1'b0;
    #1;
    chk("mid_rst_busy", BUSY, 0);
    chk("mid_rst_done", DONE, 0);
    chk("mid_rst_q_neg", Q_NEG, 0);
    chk_ovf("mid_rst_ovf", 1'b0);
    d0 = done_cnt;
    @(negedge CLK);
    RST_N = 1'b1;
    repeat (15) @(negedge CLK);
    chk("no_done_after_reset", done_cnt - d0, 0);
    chk("idle_after_reset", BUSY, 0);
    do_op(8'h7F, 8'h81, 1'b0, -1);

    // Back-to-back: second START is asserted during the DONE cycle.
    repeat (2) @(negedge CLK);
    do_op(8'h01, 8'hFF, 1'b0, -1);
    t1 = last_done_t;
    do_op(8'hFF, 8'h01, 1'b0, -1);
    chk("b2b_done_spacing", (last_done_t - t1) / PERIOD, W + 2);

    for (int i = 0; i < 20; i++) begin
      rq = W'($urandom);
      if (i == 0) rq = 8'h80;
      @(negedge CLK);
      do_op(rq, model_neg(rq), model_ovf(rq), -1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
